// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin arbiter sharing one single-byte SPI master among NREQ requesters.
// Define SPI_ARB_TIMEOUT_EN to abort transfers the master has not finished within TIMEOUT cycles.
module spi_txn_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] req_sel,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        rsp_data,
    output logic              err,
    output logic              busy,
    output logic              m_start,
    output logic [1:0]        m_slave_sel,
    output logic [7:0]        m_mosi_data,
    input  logic              m_sending,
    input  logic              m_done,
    input  logic [7:0]        m_miso_data
);
    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
        $error("spi_txn_arbiter: NREQ must be 2..8 and TIMEOUT 2..255");
    end

`ifdef SPI_ARB_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RESP, DRAIN} state_e;
    logic [7:0] cnt_q, cnt_d;
`else
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_e;
`endif

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, win;
    logic [NREQ-1:0] gnt_q, gnt_d, ack_q, ack_d, win_oh;
    logic [7:0]      rsp_q, rsp_d, mosi_q, mosi_d;
    logic [1:0]      sel_q, sel_d, win_sel;
    logic            err_q, err_d, start_q, start_d;

    always_comb begin
        win = '0;
        // Scan downward so the requester closest at-or-after the pointer wins.
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[IW'((int'(ptr_q) + i) % NREQ)]) win = IW'((int'(ptr_q) + i) % NREQ);
        win_oh  = NREQ'(1) << win;
        win_sel = req_sel[2*win +: 2];
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        err_d   = 1'b0;
        rsp_d   = rsp_q;
        start_d = start_q;
        sel_d   = sel_q;
        mosi_d  = mosi_q;
        case (state_q)
            IDLE: if (|req) begin
                gnt_d  = win_oh;
                ptr_d  = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
                sel_d  = win_sel;
                mosi_d = req_data[8*win +: 8];
                if (win_sel == 2'b11) begin
                    state_d = RESP;
                    ack_d   = win_oh;
                    err_d   = 1'b1;
                    rsp_d   = 8'h00;
                end else begin
                    state_d = LAUNCH;
                    start_d = 1'b1;
                end
            end
            LAUNCH: if (m_sending) begin
                start_d = 1'b0;
                state_d = WAIT;
            end
            WAIT: if (m_done) begin
                rsp_d   = m_miso_data;
                ack_d   = gnt_q;
                state_d = RESP;
            end
            RESP: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            DRAIN: if (!m_sending) begin
                rsp_d   = 8'hFF;
                ack_d   = gnt_q;
                err_d   = 1'b1;
                state_d = RESP;
            end
`endif
            default: state_d = IDLE;
        endcase
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d = (state_q == LAUNCH || state_q == WAIT) ? cnt_q + 8'd1 : 8'd0;
        // A completing m_done in the same cycle as expiry takes precedence.
        if ((state_q == LAUNCH || (state_q == WAIT && !m_done)) && cnt_q == 8'(TIMEOUT - 1)) begin
            start_d = 1'b0;
            state_d = DRAIN;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            rsp_q   <= 8'h00;
            start_q <= 1'b0;
            sel_q   <= 2'b00;
            mosi_q  <= 8'h00;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rsp_q   <= rsp_d;
            start_q <= start_d;
            sel_q   <= sel_d;
            mosi_q  <= mosi_d;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign gnt         = gnt_q;
    assign ack         = ack_q;
    assign err         = err_q;
    assign rsp_data    = rsp_q;
    assign m_start     = start_q;
    assign m_slave_sel = sel_q;
    assign m_mosi_data = mosi_q;
    assign busy        = state_q != IDLE;
endmodule
